// File: rtl/fifo_sync.sv
// fifo_sync: single-clock synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty flags and one-cycle overflow/underflow pulses.
// Read data is registered (one-cycle latency after an accepted pop).
// Optional build macro FIFO_PARITY_EN: stores an even-parity bit per word and
// adds the parity_err output, which is registered alongside data_out.
module fifo_sync #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
`ifdef FIFO_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef FIFO_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AF_CNT    = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AE_CNT    = AE_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;

    // Storage is deliberately not reset; stale words are unreachable once the
    // pointers and count are cleared.
    logic [MEM_W-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
`ifdef FIFO_PARITY_EN
    logic                  parity_err_q, parity_err_d;
`endif

    logic                  full_w;
    logic                  empty_w;
    logic                  push_ok;
    logic                  pop_ok;
    logic [MEM_W-1:0]      wr_word;
    logic [MEM_W-1:0]      rd_word;

    // Status decode from the registered count only, so push/pop never reach an output.
    always_comb begin
        full_w  = (count_q == DEPTH_CNT);
        empty_w = (count_q == '0);
    end

    // Acceptance: a push into a full FIFO is allowed when a pop frees a slot on the
    // same edge; a pop is allowed whenever something is stored.
    always_comb begin
        push_ok = push && (!full_w || pop);
        pop_ok  = pop && !empty_w;
    end

    // Word formatting for storage and the addressed read word.
    always_comb begin
`ifdef FIFO_PARITY_EN
        wr_word = {^data_in, data_in};
`else
        wr_word = data_in;
`endif
        rd_word = mem_q[rd_ptr_q];
    end

    // Next-state for pointers, count, read data and error pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        overflow_d  = push && !push_ok;
        underflow_d = pop && !pop_ok;
`ifdef FIFO_PARITY_EN
        parity_err_d = 1'b0;
`endif

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (pop_ok) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            data_out_d  = rd_word[DATA_WIDTH-1:0];
            valid_out_d = 1'b1;
`ifdef FIFO_PARITY_EN
            parity_err_d = (^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH];
`endif
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Word storage; a read of the same address on this edge sees the old word.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef FIFO_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifdef FIFO_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Output mapping.
    always_comb begin
        data_out     = data_out_q;
        valid_out    = valid_out_q;
        count        = count_q;
        full         = full_w;
        empty        = empty_w;
        almost_full  = (count_q >= AF_CNT);
        almost_empty = (count_q <= AE_CNT);
        overflow     = overflow_q;
        underflow    = underflow_q;
`ifdef FIFO_PARITY_EN
        parity_err   = parity_err_q;
`endif
    end

endmodule
